// File: rtl/kronos_mem_arb.sv
// kronos_mem_arb
//   Shares one synchronous single-port memory bus between the instruction
//   fetch port and the load/store data port.
//   - One command is outstanding at a time.
//   - A new command may issue on the same cycle as the previous command's ack,
//     so a 1-cycle memory sees one transfer per cycle.
//   - The data port wins a collision. A streak limiter lets fetch through after
//     DATA_STREAK_MAX back-to-back data grants.
//
// Configuration macro: KRONOS_MEM_ARB_TIMEOUT_EN
//   When defined, a command that sees no mem_ack for TIMEOUT_CYCLES busy cycles
//   is abandoned. A data command then completes with data_ack=1 and data_err=1.
//   A fetch command is dropped silently, and fetch re-requests on its own.
//   When undefined, the arbiter waits indefinitely and data_err is tied to 0.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   instr_addr/req                fetch request (address may change every cycle)
//   instr_data/ack                fetch response (instr_data = mem_rdata)
//   data_addr/req/we/mask/wdata   load/store request, held until data_ack
//   data_rdata/ack/err            load/store response (data_err qualifies data_ack)
//   mem_addr/req/we/wmask/wdata   memory command (mem_req is a one-cycle strobe)
//   mem_rdata/ack                 memory response for the outstanding command
//
// owner encoding
//   OWN_I | outstanding command belongs to fetch
//   OWN_D | outstanding command belongs to the data port

module kronos_mem_arb #(
  parameter int DATA_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  input  logic [31:0] data_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  if (DATA_STREAK_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("kronos_mem_arb: DATA_STREAK_MAX and TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [0:0] OWN_I = 1'b0;
  localparam logic [0:0] OWN_D = 1'b1;

  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  logic          busy_q, busy_d;
  logic [0:0]    owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;

  logic free;
  logic issue;
  logic grant_d;
  logic grant_i;
  logic streak_full;
  logic ack_live;
  logic tmo_fire;

`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // The counter holds (busy cycles without ack) - 1, so the abort fires during
  // the TIMEOUT_CYCLES-th busy cycle that has no mem_ack.
  always_comb begin
    tmo_fire = busy_q & ~mem_ack & ~rst & (tmo_q == TMO_LAST);
    tmo_d    = tmo_q;
    if (issue || tmo_fire) begin
      tmo_d = '0;
    end else if (busy_q && !mem_ack) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    free        = ~busy_q | mem_ack;
    issue       = free & (instr_req | data_req) & ~rst;
    streak_full = (streak_q == STREAK_MAX);
    grant_d     = data_req & ~(instr_req & streak_full);
    grant_i     = instr_req & ~grant_d;
    // A stale ack arriving while idle, for example just after reset, is ignored
    // because busy_q is low.
    ack_live    = busy_q & mem_ack & ~rst;
  end

  always_comb begin
    mem_req   = issue;
    mem_wdata = data_wdata;
    if (issue && grant_i) begin
      mem_addr  = instr_addr;
      mem_we    = 1'b0;
      mem_wmask = 4'b0000;
    end else begin
      mem_addr  = data_addr;
      mem_we    = data_we;
      mem_wmask = data_mask;
    end
  end

  // Acks always go to the owner of the command that is completing, even when a
  // grant to the other port issues in the same cycle.
  always_comb begin
    instr_data = mem_rdata;
    data_rdata = mem_rdata;
    instr_ack  = ack_live & (owner_q == OWN_I);
    data_err   = tmo_fire & (owner_q == OWN_D);
    data_ack   = (ack_live & (owner_q == OWN_D)) | data_err;
  end

  always_comb begin
    busy_d   = busy_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    if (issue) begin
      busy_d  = 1'b1;
      owner_d = grant_d ? OWN_D : OWN_I;
    end else if (free || tmo_fire) begin
      busy_d = 1'b0;
    end

    if (!instr_req || (issue && grant_i)) begin
      streak_d = '0;
    end else if (issue && grant_d && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      owner_q  <= OWN_I;
      streak_q <= '0;
    end else begin
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

// File: tb/tb_kronos_mem_arb.sv
module tb_kronos_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic [31:0] data_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_mask;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        data_err;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_total = 0;
  int n_bad   = 0;

  kronos_mem_arb #(
    .DATA_STREAK_MAX(4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .instr_addr(instr_addr),
    .instr_req (instr_req),
    .instr_data(instr_data),
    .instr_ack (instr_ack),
    .data_addr (data_addr),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_mask (data_mask),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ack  (data_ack),
    .data_err  (data_err),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    instr_addr = 32'h0;
    instr_req  = 1'b1;
    data_addr  = 32'h0;
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_mask  = 4'h0;
    data_wdata = 32'h0;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b1;
    #2;
    chk("rst mem_req", mem_req, 0);
    chk("rst instr_ack", instr_ack, 0);
    chk("rst data_ack", data_ack, 0);
    chk("rst data_err", data_err, 0);
    tick;
    tick;
    rst       = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    mem_ack   = 1'b0;
    settle;
    chk("idle mem_req", mem_req, 0);
    tick;

    // Test 1: fetch stream with a 1-cycle memory.
    instr_req = 1'b1; instr_addr = 32'h0;
    settle;
    chk("t1 c0 mem_req", mem_req, 1);
    chk("t1 c0 mem_addr", mem_addr, 32'h0);
    chk("t1 c0 instr_ack", instr_ack, 0);
    tick;
    instr_addr = 32'h4; mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    settle;
    chk("t1 c1 instr_ack", instr_ack, 1);
    chk("t1 c1 instr_data", instr_data, 32'h1111_0000);
    chk("t1 c1 mem_req", mem_req, 1);
    chk("t1 c1 mem_addr", mem_addr, 32'h4);
    tick;
    instr_addr = 32'h8; mem_rdata = 32'h1111_0004;
    settle;
    chk("t1 c2 instr_ack", instr_ack, 1);
    chk("t1 c2 mem_req", mem_req, 1);
    chk("t1 c2 mem_addr", mem_addr, 32'h8);
    tick;
    instr_req = 1'b0; mem_rdata = 32'h1111_0008;
    settle;
    chk("t1 c3 instr_ack", instr_ack, 1);
    chk("t1 c3 instr_data", instr_data, 32'h1111_0008);
    chk("t1 c3 mem_req", mem_req, 0);
    tick;
    settle;
    chk("t1 stray ack ignored", instr_ack, 0);
    tick;
    mem_ack = 1'b0;

    // Test 2: collision, data wins, fetch issues on the data ack cycle.
    instr_req = 1'b1; instr_addr = 32'h100;
    data_req = 1'b1; data_addr = 32'h2000; data_we = 1'b0; data_mask = 4'h0;
    settle;
    chk("t2 c0 mem_req", mem_req, 1);
    chk("t2 c0 mem_addr", mem_addr, 32'h2000);
    chk("t2 c0 mem_we", mem_we, 0);
    tick;
    data_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    settle;
    chk("t2 c1 data_ack", data_ack, 1);
    chk("t2 c1 data_rdata", data_rdata, 32'hCAFE_0001);
    chk("t2 c1 instr_ack", instr_ack, 0);
    chk("t2 c1 mem_req", mem_req, 1);
    chk("t2 c1 mem_addr", mem_addr, 32'h100);
    tick;
    instr_req = 1'b0; mem_rdata = 32'hCAFE_0002;
    settle;
    chk("t2 c2 instr_ack", instr_ack, 1);
    chk("t2 c2 data_ack", data_ack, 0);
    chk("t2 c2 instr_data", instr_data, 32'hCAFE_0002);
    tick;
    mem_ack = 1'b0;
    tick;

    // Test 3: both held high, the streak limiter gives D,D,D,D,I repeating.
    instr_req = 1'b1; instr_addr = 32'h400;
    data_req = 1'b1; data_addr = 32'h3000;
    for (int k = 0; k < 10; k++) begin
      mem_ack = (k > 0);
      settle;
      chk($sformatf("t3 grant%0d addr", k), mem_addr, ((k % 5) == 4) ? 32'h400 : 32'h3000);
      chk($sformatf("t3 grant%0d req", k), mem_req, 1);
      if (k > 0) begin
        chk($sformatf("t3 ack%0d data", k), data_ack, (((k - 1) % 5) != 4) ? 1 : 0);
      end
      tick;
    end
    instr_req = 1'b0; data_req = 1'b0; mem_ack = 1'b1;
    settle;
    chk("t3 last instr_ack", instr_ack, 1);
    chk("t3 last mem_req", mem_req, 0);
    tick;
    mem_ack = 1'b0;
    tick;

    // Test 4: a 3-cycle memory; store fields pass through, fetch fields are forced.
    instr_req = 1'b1; instr_addr = 32'h600;
    data_req = 1'b1; data_addr = 32'h5000; data_we = 1'b1; data_mask = 4'b0011;
    data_wdata = 32'hDEAD_BEEF;
    settle;
    chk("t4 c0 mem_req", mem_req, 1);
    chk("t4 c0 mem_addr", mem_addr, 32'h5000);
    chk("t4 c0 mem_we", mem_we, 1);
    chk("t4 c0 mem_wmask", mem_wmask, 4'b0011);
    chk("t4 c0 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick;
    settle;
    chk("t4 c1 mem_req", mem_req, 0);
    tick;
    settle;
    chk("t4 c2 mem_req", mem_req, 0);
    chk("t4 c2 data_ack", data_ack, 0);
    tick;
    data_req = 1'b0; mem_ack = 1'b1;
    settle;
    chk("t4 c3 data_ack", data_ack, 1);
    chk("t4 c3 mem_req", mem_req, 1);
    chk("t4 c3 mem_addr", mem_addr, 32'h600);
    chk("t4 c3 mem_we", mem_we, 0);
    chk("t4 c3 mem_wmask", mem_wmask, 4'b0000);
    tick;
    instr_req = 1'b0;
    settle;
    chk("t4 c4 instr_ack", instr_ack, 1);
    chk("t4 c4 mem_req", mem_req, 0);
    tick;
    mem_ack = 1'b0;
    tick;

    // Test 5: a store that never gets a mem_ack.
    data_req = 1'b1; data_addr = 32'h6000; data_we = 1'b1; data_mask = 4'hF;
    data_wdata = 32'h0BAD_F00D;
    settle;
    chk("t5 issue mem_req", mem_req, 1);
    tick;
    for (int k = 1; k < 16; k++) begin
      settle;
      chk($sformatf("t5 wait%0d data_ack", k), data_ack, 0);
      chk($sformatf("t5 wait%0d mem_req", k), mem_req, 0);
      tick;
    end
    settle;
`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    chk("t5 c16 data_ack", data_ack, 1);
    chk("t5 c16 data_err", data_err, 1);
`else
    chk("t5 c16 data_ack", data_ack, 0);
    chk("t5 c16 data_err", data_err, 0);
`endif
    chk("t5 c16 mem_req", mem_req, 0);
    tick;
`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    data_req = 1'b0;
`endif
    settle;
    chk("t5 c17 data_ack", data_ack, 0);
    chk("t5 c17 data_err", data_err, 0);
    tick;
    data_req = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h800;
    settle;
`ifdef KRONOS_MEM_ARB_TIMEOUT_EN
    chk("t5 after mem_req", mem_req, 1);
`else
    chk("t5 after mem_req", mem_req, 0);
`endif
    instr_req = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;

    // Test 6: reset while a load is outstanding; the late ack is discarded.
    data_req = 1'b1; data_addr = 32'h7000; data_we = 1'b0; data_mask = 4'h0;
    settle;
    chk("t6 c0 mem_req", mem_req, 1);
    tick;
    settle;
    rst = 1'b1; mem_ack = 1'b1;
    settle;
    chk("t6 in rst data_ack", data_ack, 0);
    chk("t6 in rst instr_ack", instr_ack, 0);
    chk("t6 in rst mem_req", mem_req, 0);
    tick;
    rst = 1'b0; mem_ack = 1'b0; data_req = 1'b0;
    settle;
    chk("t6 release mem_req", mem_req, 0);
    tick;
    mem_ack = 1'b1;
    settle;
    chk("t6 late data_ack", data_ack, 0);
    chk("t6 late instr_ack", instr_ack, 0);
    tick;
    mem_ack = 1'b0; data_req = 1'b1; data_addr = 32'h7004;
    settle;
    chk("t6 reissue mem_req", mem_req, 1);
    chk("t6 reissue mem_addr", mem_addr, 32'h7004);
    tick;
    data_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    settle;
    chk("t6 reissue data_ack", data_ack, 1);
    chk("t6 reissue data_rdata", data_rdata, 32'h55AA_55AA);
    tick;
    mem_ack = 1'b0;
    tick;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
